issue_scoreboard: RTL
=====================

# issue_scoreboard

Decode-to-execute issue controller for the rv32i pipeline. It holds one decoded instruction in the ID stage register and tracks pending register-file writes with a per-register busy scoreboard. It issues the instruction to the execute stage only when no RAW or WAW hazard exists and the in-flight limit has headroom. It sits between the instruction decoder and the execute stage, and completes the write-back loop from the register-file write port.

## Interface
Parameters:
- C_MAX_INFLIGHT, 4, maximum issued-but-not-written-back instructions (1..15); counter width is clog2(C_MAX_INFLIGHT+1)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- resetb_i  in  1  reset; asynchronous and active-low
- flush_i  in  1  kills the held ID entry (branch/exception redirect)
- ids_valid_i  in  1  decoded instruction available
- ids_ready_o  out  1  ID register can accept
- ids_ins_err_i  in  1  decoder flagged illegal instruction
- ids_regd_addr_i  in  5  destination register
- ids_regs1_addr_i  in  5  source 1
- ids_regs2_addr_i  in  5  source 2
- ids_uses_rs1_i  in  1  instruction reads rs1
- ids_uses_rs2_i  in  1  instruction reads rs2
- ids_writes_rd_i  in  1  instruction writes rd
- exs_valid_o  out  1  issue request to execute
- exs_ready_i  in  1  execute accepts
- exs_ins_err_o  out  1  held ins_err
- exs_regd_addr_o  out  5  held rd
- exs_writes_rd_o  out  1  held writes_rd, forced 0 for ins_err or rd==0
- wb_valid_i  in  1  one issued instruction completed
- wb_addr_i  in  5  its rd (0 if none)
- inflight_o  out  clog2(C_MAX_INFLIGHT+1)  current in-flight count

## Operation
- ID register: valid bit plus held fields. ids_ready_o = !held_valid || issue. An accept (ids_valid_i && ids_ready_o) loads the fields and sets held_valid. An issue with no accept clears held_valid.
- Scoreboard: busy[31:1]. busy[0] is constant 0.
- Hazard = held_valid && !held_err && ((uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd])).
- Full = inflight == C_MAX_INFLIGHT.
- exs_valid_o = held_valid && !flush_i && !hazard && (held_err || !full).
- Issue = exs_valid_o && exs_ready_i.
- Issue of a non-error entry: inflight +1. If exs_writes_rd_o, busy[rd] is set.
- Issue of an ins_err entry: no hazard check, no scoreboard update, no inflight change. No write-back follows.
- wb_valid_i: inflight −1 and busy[wb_addr_i] cleared (no effect for addr 0).
- Simultaneous issue and wb_valid_i: inflight is unchanged. If the same register is set and cleared, set wins.
- wb_valid_i with inflight==0 is a protocol error. inflight holds at 0 and busy clears normally.
- flush_i:
  - held_valid clears at the next edge.
  - Any accept handshake in the flush cycle is discarded.
  - exs_valid_o is 0 in the flush cycle.
  - Scoreboard and inflight are untouched; older in-flight instructions still write back.
- Output fields hold stable while exs_valid_o && !exs_ready_i.

## Timing
- Reset values: held_valid=0, all busy=0, inflight_o=0, ids_ready_o=1, exs_valid_o=0, exs_ins_err_o=0, exs_regd_addr_o=0, exs_writes_rd_o=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Pending write-backs are abandoned.
- Accept to earliest exs_valid_o: 1 cycle (registered stage).
- Back-to-back issue at 1 per cycle when hazard-free and not full.
- Dependent instruction (RAW on previous rd): stalls until the cycle after wb_valid_i for that rd. With ISSUE_SB_BYPASS_EN it can issue in the wb cycle itself.
- exs_valid_o, ids_ready_o: combinational from state and exs_ready_i, flush_i (plus wb_valid_i/wb_addr_i under bypass). No combinational path from ids_* to exs_*.

## Configuration
- ISSUE_SB_BYPASS_EN defined:
  - Hazard and full evaluation use busy with the current-cycle wb_addr_i masked off, and inflight minus the current wb.
  - A waiting instruction can issue in the same cycle its blocking write-back arrives.
- Undefined: hazard and full use registered state only. Issue happens one cycle after the write-back. There is no wb_*→exs_valid_o combinational path.

## Test plan
- Reset then independent stream: addi x1,x0,1 and addi x2,x0,2 accepted in consecutive cycles, exs_ready_i=1 -> issues on cycles 1 and 2, busy[1], busy[2] set, inflight_o=2.
- RAW stall: issue writes x5, next reads x5; wb_valid_i, wb_addr_i=5 at cycle 4 -> issue at cycle 5 (cycle 4 with ISSUE_SB_BYPASS_EN), ids_ready_o=0 meanwhile.
- Full: C_MAX_INFLIGHT=4, four issues, no wb -> fifth held with exs_valid_o=0. One wb -> fifth issues next cycle. Simultaneous issue+wb keeps inflight_o=4.
- ins_err entry with busy conflict on rd -> issues immediately with exs_ins_err_o=1, exs_writes_rd_o=0, inflight unchanged.
- Flush with held entry stalled on hazard and new ids_valid_i=1 -> held entry dropped, new entry not loaded, busy bits and inflight_o unchanged. Pending wb still clears busy.
- x0: write to rd=0 issues with exs_writes_rd_o=0. Reader of x0 is never stalled. Async resetb_i low mid-stall -> all outputs to reset values without a clock edge.

Source files
------------

// File: rtl/issue_scoreboard.sv
// ID-stage issue controller: holds one decoded instruction and issues it to execute once the
// busy scoreboard and in-flight limit allow. Optional same-cycle write-back bypass: ISSUE_SB_BYPASS_EN.
module issue_scoreboard #(
  parameter int C_MAX_INFLIGHT = 4,
  localparam int CW = $clog2(C_MAX_INFLIGHT + 1)
) (
  input  logic          clk_i,
  input  logic          resetb_i,
  input  logic          flush_i,
  input  logic          ids_valid_i,
  output logic          ids_ready_o,
  input  logic          ids_ins_err_i,
  input  logic [4:0]    ids_regd_addr_i,
  input  logic [4:0]    ids_regs1_addr_i,
  input  logic [4:0]    ids_regs2_addr_i,
  input  logic          ids_uses_rs1_i,
  input  logic          ids_uses_rs2_i,
  input  logic          ids_writes_rd_i,
  output logic          exs_valid_o,
  input  logic          exs_ready_i,
  output logic          exs_ins_err_o,
  output logic [4:0]    exs_regd_addr_o,
  output logic          exs_writes_rd_o,
  input  logic          wb_valid_i,
  input  logic [4:0]    wb_addr_i,
  output logic [CW-1:0] inflight_o
);

  logic          r_held_valid;
  logic          r_held_err;
  logic [4:0]    r_rd;
  logic [4:0]    r_rs1;
  logic [4:0]    r_rs2;
  logic          r_uses_rs1;
  logic          r_uses_rs2;
  logic          r_writes_rd;
  logic [31:0]   r_busy;
  logic [CW-1:0] r_inflight;

  logic [31:0]   w_busy_eff;
  logic [CW-1:0] w_inflight_eff;
  logic          w_dec;
  logic          w_inc;
  logic          w_hazard;
  logic          w_full;
  logic          w_issue;
  logic          w_accept;
  logic          w_held_valid_nxt;
  logic [31:0]   w_busy_nxt;
  logic [CW-1:0] w_inflight_nxt;

  // A write-back with nothing in flight is ignored for counting but still clears busy.
  assign w_dec = wb_valid_i && (r_inflight != '0);

`ifdef ISSUE_SB_BYPASS_EN
  always_comb begin
    w_busy_eff = r_busy;
    if (wb_valid_i) w_busy_eff[wb_addr_i] = 1'b0;
  end
  assign w_inflight_eff = r_inflight - CW'(w_dec);
`else
  assign w_busy_eff     = r_busy;
  assign w_inflight_eff = r_inflight;
`endif

  assign w_hazard = r_held_valid && !r_held_err &&
                    ((r_uses_rs1 && w_busy_eff[r_rs1]) ||
                     (r_uses_rs2 && w_busy_eff[r_rs2]) ||
                     (r_writes_rd && w_busy_eff[r_rd]));
  assign w_full   = (w_inflight_eff == CW'(C_MAX_INFLIGHT));

  assign exs_valid_o     = r_held_valid && !flush_i && !w_hazard && (r_held_err || !w_full);
  assign w_issue         = exs_valid_o && exs_ready_i;
  assign ids_ready_o     = !r_held_valid || w_issue;
  assign w_accept        = ids_valid_i && ids_ready_o && !flush_i;
  assign w_inc           = w_issue && !r_held_err;

  assign exs_ins_err_o   = r_held_err;
  assign exs_regd_addr_o = r_rd;
  assign exs_writes_rd_o = r_writes_rd && !r_held_err && (r_rd != 5'd0);
  assign inflight_o      = r_inflight;

  always_comb begin
    w_held_valid_nxt = r_held_valid;
    if (flush_i)       w_held_valid_nxt = 1'b0;
    else if (w_accept) w_held_valid_nxt = 1'b1;
    else if (w_issue)  w_held_valid_nxt = 1'b0;
  end

  // Clear before set so an issue and write-back to the same register leaves it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid_i) w_busy_nxt[wb_addr_i] = 1'b0;
    if (w_issue && exs_writes_rd_o) w_busy_nxt[r_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_inc && !w_dec)      w_inflight_nxt = r_inflight + CW'(1);
    else if (w_dec && !w_inc) w_inflight_nxt = r_inflight - CW'(1);
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_held_valid <= 1'b0;
      r_held_err   <= 1'b0;
      r_rd         <= 5'd0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_uses_rs1   <= 1'b0;
      r_uses_rs2   <= 1'b0;
      r_writes_rd  <= 1'b0;
      r_busy       <= 32'd0;
      r_inflight   <= '0;
    end else begin
      r_held_valid <= w_held_valid_nxt;
      if (w_accept) begin
        r_held_err  <= ids_ins_err_i;
        r_rd        <= ids_regd_addr_i;
        r_rs1       <= ids_regs1_addr_i;
        r_rs2       <= ids_regs2_addr_i;
        r_uses_rs1  <= ids_uses_rs1_i;
        r_uses_rs2  <= ids_uses_rs2_i;
        r_writes_rd <= ids_writes_rd_i;
      end
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

endmodule
